// File: rtl/conflict_monitor.sv
// Independent safety reader of the light-code bus: detects conflicting greens, invalid codes,
// skipped and short yellows, latches the first fault and drives the flashing override.
module conflict_monitor #(
    parameter int unsigned PERSIST_CYCLES    = 3,
    parameter int unsigned MIN_YELLOW_CYCLES = 30000,
    parameter int unsigned BLANK_CYCLES      = 10,
    parameter int unsigned FLASH_HALF_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] light_th,
    input  logic [1:0] light_nn,
    input  logic [1:0] light_ns,
    input  logic [1:0] light_gth,
    input  logic [1:0] light_gnn_l,
    input  logic [1:0] light_gnn_r,
    input  logic [1:0] light_pn,
    input  logic [1:0] light_pth1,
    input  logic [1:0] light_pth2,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       override,
    output logic       flash
);

    localparam int PW = $clog2(PERSIST_CYCLES + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam int FW = $clog2(FLASH_HALF_CYCLES + 1);

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_CONFLICT = 3'd1;
    localparam logic [2:0] CODE_SKIP     = 3'd2;
    localparam logic [2:0] CODE_SHORT    = 3'd3;
    localparam logic [2:0] CODE_INVALID  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_MONITOR,
        S_FAULT
    } state_t;

    function automatic logic veh_active(input logic [1:0] c);
        return (c == 2'b01) || (c == 2'b10);
    endfunction

    function automatic logic two_active(input logic [1:0] c);
        return c == 2'b10;
    endfunction

    function automatic logic veh_invalid(input logic [1:0] c);
        return c == 2'b11;
    endfunction

    function automatic logic two_invalid(input logic [1:0] c);
        return c[0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           state_q, state_d;
    logic [BW-1:0]    blank_cnt_q, blank_cnt_d;
    logic [PW-1:0]    conflict_cnt_q, conflict_cnt_d;
    logic [PW-1:0]    invalid_cnt_q, invalid_cnt_d;
    logic [2:0][15:0] yel_cnt_q, yel_cnt_d;
    logic [2:0][1:0]  prev_q, prev_d;
    logic [FW-1:0]    flash_cnt_q, flash_cnt_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;
    logic             flash_q, flash_d;

    // Index 0 = Thevenin, 1 = Norton-N, 2 = Norton-S vehicle heads.
    logic [2:0][1:0]  veh_cur;
    logic             a_th, a_nn, a_ns, a_gth, a_gl, a_gr, a_pn, a_p1, a_p2;
    logic             conflict_now, invalid_now;
    logic             hit_conflict, hit_invalid;
    logic [2:0]       skip_vec, short_vec;
    logic [2:0]       det_code;

    assign veh_cur = {light_ns, light_nn, light_th};

    assign a_th  = veh_active(light_th);
    assign a_nn  = veh_active(light_nn);
    assign a_ns  = veh_active(light_ns);
    assign a_gth = two_active(light_gth);
    assign a_gl  = two_active(light_gnn_l);
    assign a_gr  = two_active(light_gnn_r);
    assign a_pn  = two_active(light_pn);
    assign a_p1  = two_active(light_pth1);
    assign a_p2  = two_active(light_pth2);

    assign conflict_now = (a_th  & (a_nn | a_ns | a_gl | a_gr | a_pn))
                        | (a_gth & (a_nn | a_ns | a_pn | a_p1 | a_p2))
                        | (a_gl  & (a_ns | a_p1 | a_p2))
                        | (a_gr  & (a_p1 | a_p2))
                        | ((a_nn | a_ns) & (a_p1 | a_p2));

    assign invalid_now = veh_invalid(light_th) | veh_invalid(light_nn) | veh_invalid(light_ns)
                       | two_invalid(light_gth) | two_invalid(light_gnn_l)
                       | two_invalid(light_gnn_r) | two_invalid(light_pn)
                       | two_invalid(light_pth1) | two_invalid(light_pth2);

    // A persistence hit means this cycle would be the PERSIST_CYCLES-th in a row.
    assign hit_conflict = conflict_now && ((32'(conflict_cnt_q) + 32'd1) >= PERSIST_CYCLES);
    assign hit_invalid  = invalid_now  && ((32'(invalid_cnt_q)  + 32'd1) >= PERSIST_CYCLES);

    always_comb begin
        skip_vec  = '0;
        short_vec = '0;
        for (int h = 0; h < 3; h++) begin
            skip_vec[h]  = (prev_q[h] == 2'b10) && (veh_cur[h] == 2'b00);
            short_vec[h] = (prev_q[h] == 2'b01) && (veh_cur[h] == 2'b00)
                           && (32'(yel_cnt_q[h]) < MIN_YELLOW_CYCLES);
        end
    end

    always_comb begin
        det_code = CODE_NONE;
        if (hit_conflict)     det_code = CODE_CONFLICT;
        else if (hit_invalid) det_code = CODE_INVALID;
        else if (|skip_vec)   det_code = CODE_SKIP;
        else if (|short_vec)  det_code = CODE_SHORT;
    end

    always_comb begin
        state_d        = state_q;
        blank_cnt_d    = blank_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        invalid_cnt_d  = invalid_cnt_q;
        yel_cnt_d      = yel_cnt_q;
        prev_d         = veh_cur;
        flash_cnt_d    = flash_cnt_q;
        fault_d        = fault_q;
        code_d         = code_q;
        flash_d        = flash_q;
        case (state_q)
            S_IDLE: begin
                blank_cnt_d    = '0;
                conflict_cnt_d = '0;
                invalid_cnt_d  = '0;
                yel_cnt_d      = '0;
                if (enable) state_d = S_BLANK;
            end
            S_BLANK: begin
                if (!enable) begin
                    state_d     = S_IDLE;
                    blank_cnt_d = '0;
                end else if (blank_cnt_q == BW'(BLANK_CYCLES - 1)) begin
                    state_d     = S_MONITOR;
                    blank_cnt_d = '0;
                end else begin
                    blank_cnt_d = blank_cnt_q + BW'(1);
                end
            end
            S_MONITOR: begin
                if (!enable) begin
                    state_d        = S_IDLE;
                    conflict_cnt_d = '0;
                    invalid_cnt_d  = '0;
                    yel_cnt_d      = '0;
                end else begin
                    conflict_cnt_d = conflict_now
                        ? ((conflict_cnt_q == PW'(PERSIST_CYCLES)) ? conflict_cnt_q : conflict_cnt_q + PW'(1))
                        : '0;
                    invalid_cnt_d  = invalid_now
                        ? ((invalid_cnt_q == PW'(PERSIST_CYCLES)) ? invalid_cnt_q : invalid_cnt_q + PW'(1))
                        : '0;
                    for (int h = 0; h < 3; h++) begin
                        yel_cnt_d[h] = (veh_cur[h] == 2'b01) ? sat_inc16(yel_cnt_q[h]) : 16'd0;
                    end
                    if (det_code != CODE_NONE) begin
                        state_d     = S_FAULT;
                        fault_d     = 1'b1;
                        code_d      = det_code;
                        flash_d     = 1'b0;
                        flash_cnt_d = '0;
                    end
                end
            end
            S_FAULT: begin
                prev_d = prev_q;
                if (flash_cnt_q == FW'(FLASH_HALF_CYCLES - 1)) begin
                    flash_cnt_d = '0;
                    flash_d     = ~flash_q;
                end else begin
                    flash_cnt_d = flash_cnt_q + FW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            blank_cnt_q    <= '0;
            conflict_cnt_q <= '0;
            invalid_cnt_q  <= '0;
            yel_cnt_q      <= '0;
            prev_q         <= '0;
            flash_cnt_q    <= '0;
            fault_q        <= 1'b0;
            code_q         <= CODE_NONE;
            flash_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            blank_cnt_q    <= blank_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
            invalid_cnt_q  <= invalid_cnt_d;
            yel_cnt_q      <= yel_cnt_d;
            prev_q         <= prev_d;
            flash_cnt_q    <= flash_cnt_d;
            fault_q        <= fault_d;
            code_q         <= code_d;
            flash_q        <= flash_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign override   = fault_q;
    assign flash      = flash_q;

endmodule

// File: tb/tb_conflict_monitor.sv
// Bench for conflict_monitor: scenario tasks queue the expected fault/code after every clock
// edge; a falling-edge scoreboard pops and compares, and tasks add their own inline checks.
module tb_conflict_monitor;

    localparam int unsigned P_PERSIST = 3;
    localparam int unsigned P_MIN_Y   = 200;
    localparam int unsigned P_BLANK   = 10;
    localparam int unsigned P_HALF    = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] th, nn, ns, gth, gl, gr, pn, p1, p2;
    logic       fault, override, flash;
    logic [2:0] fault_code;

    typedef struct packed {
        logic       f;
        logic [2:0] c;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string cur_test = "none";

    always #5 clk = ~clk;

    conflict_monitor #(
        .PERSIST_CYCLES    (P_PERSIST),
        .MIN_YELLOW_CYCLES (P_MIN_Y),
        .BLANK_CYCLES      (P_BLANK),
        .FLASH_HALF_CYCLES (P_HALF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .light_th    (th),
        .light_nn    (nn),
        .light_ns    (ns),
        .light_gth   (gth),
        .light_gnn_l (gl),
        .light_gnn_r (gr),
        .light_pn    (pn),
        .light_pth1  (p1),
        .light_pth2  (p2),
        .fault       (fault),
        .fault_code  (fault_code),
        .override    (override),
        .flash       (flash)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic all_red();
        th = 2'b00; nn = 2'b00; ns = 2'b00; gth = 2'b00; gl = 2'b00;
        gr = 2'b00; pn = 2'b00; p1 = 2'b00; p2 = 2'b00;
    endtask

    // Current inputs are sampled by the next rising edge; (f, c) is what must follow it.
    task automatic tick(input logic f, input logic [2:0] c);
        @(posedge clk);
        sb.push_back({f, c});
        #1;
    endtask

    task automatic go_monitor();
        reset  = 1'b1;
        enable = 1'b0;
        all_red();
        tick(1'b0, 3'd0);
        reset  = 1'b0;
        enable = 1'b1;
        repeat (P_BLANK + 1) tick(1'b0, 3'd0);
    endtask

    task automatic test_reset();
        cur_test = "reset";
        reset  = 1'b1;
        enable = 1'b1;
        all_red();
        th = 2'b10; nn = 2'b10; gth = 2'b01;
        repeat (3) tick(1'b0, 3'd0);
        checks++;
        if ({fault, override, flash, fault_code} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got fault=%b override=%b flash=%b code=%0d, required all 0",
                     fault, override, flash, fault_code);
        end
        reset  = 1'b0;
        enable = 1'b0;
        repeat (6) tick(1'b0, 3'd0);
    endtask

    task automatic test_legal_cycle();
        cur_test = "legal_cycle";
        go_monitor();
        th = 2'b10;
        repeat (5) tick(1'b0, 3'd0);
        th = 2'b01;
        repeat (P_MIN_Y) tick(1'b0, 3'd0);
        th = 2'b00;
        repeat (3) tick(1'b0, 3'd0);
        nn = 2'b10; gl = 2'b10; gr = 2'b10; pn = 2'b10;
        repeat (5) tick(1'b0, 3'd0);
        checks++;
        if (fault !== 1'b0 || flash !== 1'b0) begin
            errors++;
            $display("FAIL legal_cycle_end: got fault=%b flash=%b, required 0/0", fault, flash);
        end
    endtask

    task automatic test_conflict();
        cur_test = "conflict";
        go_monitor();
        th = 2'b10; gl = 2'b10;
        repeat (2) tick(1'b0, 3'd0);
        gl = 2'b00;
        tick(1'b0, 3'd0);
        gl = 2'b10;
        repeat (2) tick(1'b0, 3'd0);
        gl = 2'b00;
        repeat (2) tick(1'b0, 3'd0);
        nn = 2'b10;
        repeat (2) tick(1'b0, 3'd0);
        tick(1'b1, 3'd1);
        repeat (3) tick(1'b1, 3'd1);
        checks++;
        if (override !== 1'b1 || fault_code !== 3'd1) begin
            errors++;
            $display("FAIL conflict_latched: got override=%b code=%0d, required 1/1", override, fault_code);
        end
        cur_test = "conflict_ped";
        go_monitor();
        gr = 2'b10; p2 = 2'b10;
        repeat (2) tick(1'b0, 3'd0);
        tick(1'b1, 3'd1);
    endtask

    task automatic test_yellow();
        cur_test = "yellow_skip";
        go_monitor();
        ns = 2'b10;
        repeat (3) tick(1'b0, 3'd0);
        ns = 2'b00;
        tick(1'b1, 3'd2);
        repeat (2) tick(1'b1, 3'd2);

        cur_test = "yellow_short";
        go_monitor();
        ns = 2'b01;
        repeat (P_MIN_Y - 1) tick(1'b0, 3'd0);
        ns = 2'b00;
        tick(1'b1, 3'd3);

        cur_test = "yellow_exact";
        go_monitor();
        ns = 2'b01;
        repeat (P_MIN_Y) tick(1'b0, 3'd0);
        ns = 2'b00;
        repeat (3) tick(1'b0, 3'd0);

        cur_test = "yellow_in_blank";
        reset  = 1'b1;
        enable = 1'b0;
        all_red();
        tick(1'b0, 3'd0);
        reset  = 1'b0;
        enable = 1'b1;
        th = 2'b01;
        repeat (P_BLANK + 1) tick(1'b0, 3'd0);
        repeat (P_MIN_Y - 1) tick(1'b0, 3'd0);
        th = 2'b00;
        tick(1'b1, 3'd3);
    endtask

    task automatic test_invalid();
        cur_test = "invalid_gth";
        go_monitor();
        gth = 2'b01;
        repeat (2) tick(1'b0, 3'd0);
        tick(1'b1, 3'd4);

        cur_test = "invalid_broken";
        go_monitor();
        p1 = 2'b11;
        repeat (2) tick(1'b0, 3'd0);
        p1 = 2'b00;
        tick(1'b0, 3'd0);
        nn = 2'b11;
        repeat (2) tick(1'b0, 3'd0);
        tick(1'b1, 3'd4);

        cur_test = "prio_conflict_invalid";
        go_monitor();
        gth = 2'b01; th = 2'b10; nn = 2'b10;
        repeat (2) tick(1'b0, 3'd0);
        tick(1'b1, 3'd1);

        cur_test = "prio_invalid_skip";
        go_monitor();
        ns = 2'b10; gth = 2'b01;
        repeat (2) tick(1'b0, 3'd0);
        ns = 2'b00;
        tick(1'b1, 3'd4);

        cur_test = "prio_skip_short";
        go_monitor();
        ns = 2'b10; th = 2'b01;
        repeat (2) tick(1'b0, 3'd0);
        ns = 2'b00; th = 2'b00;
        tick(1'b1, 3'd2);
    endtask

    task automatic test_flash();
        logic exp_fl;
        cur_test = "flash";
        go_monitor();
        th = 2'b10; nn = 2'b10;
        repeat (2) tick(1'b0, 3'd0);
        tick(1'b1, 3'd1);
        checks++;
        if (flash !== 1'b0) begin
            errors++;
            $display("FAIL flash_entry: got flash=%b, required 0", flash);
        end
        for (int k = 1; k <= int'(2 * P_HALF + 3); k++) begin
            if (k == 7) enable = 1'b0;
            if (k == 9) begin
                th  = 2'b11;
                gth = 2'b01;
            end
            tick(1'b1, 3'd1);
            exp_fl = ((k / int'(P_HALF)) % 2) == 1;
            checks++;
            if (flash !== exp_fl) begin
                errors++;
                $display("FAIL flash_phase k=%0d: got flash=%b, required %b", k, flash, exp_fl);
            end
        end
        reset = 1'b1;
        tick(1'b0, 3'd0);
        checks++;
        if ({fault, override, flash, fault_code} !== 6'b0) begin
            errors++;
            $display("FAIL reset_from_fault: got fault=%b override=%b flash=%b code=%0d, required all 0",
                     fault, override, flash, fault_code);
        end
        reset = 1'b0;
        all_red();
        repeat (3) tick(1'b0, 3'd0);
    endtask

    task automatic test_blank();
        cur_test = "blank_suppress";
        go_monitor();
        th = 2'b10; nn = 2'b10;
        repeat (2) tick(1'b0, 3'd0);
        reset = 1'b1;
        tick(1'b0, 3'd0);
        reset = 1'b0;
        repeat (P_BLANK + 1) tick(1'b0, 3'd0);
        repeat (2) tick(1'b0, 3'd0);
        tick(1'b1, 3'd1);
        checks++;
        if (override !== 1'b1) begin
            errors++;
            $display("FAIL blank_then_fault: got override=%b, required 1", override);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        all_red();
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if ({fault, override, fault_code} !== {e.f, e.f, e.c}) begin
                        errors++;
                        $display("FAIL %s: got fault=%b override=%b code=%0d, required fault=%b override=%b code=%0d",
                                 cur_test, fault, override, fault_code, e.f, e.f, e.c);
                    end
                end
            end
        join_none
        test_reset();
        test_legal_cycle();
        test_conflict();
        test_yellow();
        test_invalid();
        test_flash();
        test_blank();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
